// File: rtl/lsu_pkg.sv
// rtl/lsu_pkg.sv - shared constants and types for the load/store unit
package lsu_pkg;

  localparam int ADDR_W_DEFAULT = 10;

  localparam logic [2:0] F3_B  = 3'b000;
  localparam logic [2:0] F3_H  = 3'b001;
  localparam logic [2:0] F3_W  = 3'b010;
  localparam logic [2:0] F3_BU = 3'b100;
  localparam logic [2:0] F3_HU = 3'b101;

  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    LOAD_WAIT = 2'd1,
    RESP      = 2'd2
  } state_t;

endpackage

// File: rtl/load_formatter.sv
// rtl/load_formatter.sv - selects the load lane from a RAM word and extends it
module load_formatter
  import lsu_pkg::*;
(
  input  logic [31:0] mem_dout,
  input  logic [1:0]  offset,
  input  logic [2:0]  funct3,
  output logic [31:0] result
);

  logic [31:0] lane;

  always_comb begin
    lane   = mem_dout >> {offset, 3'b000};
    result = lane;
    case (funct3)
      F3_B:    result = {{24{lane[7]}}, lane[7:0]};
      F3_H:    result = {{16{lane[15]}}, lane[15:0]};
      F3_BU:   result = {24'd0, lane[7:0]};
      F3_HU:   result = {16'd0, lane[15:0]};
      default: result = lane;
    endcase
  end

endmodule

// File: rtl/load_store_unit.sv
// rtl/load_store_unit.sv - RV32I load/store initiator for a byte-enabled block RAM
module load_store_unit
  import lsu_pkg::*;
#(
  parameter int ADDR_W = ADDR_W_DEFAULT
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_we,
  input  logic [2:0]        req_funct3,
  input  logic [31:0]       req_addr,
  input  logic [31:0]       req_wdata,
  output logic              rsp_valid,
  input  logic              rsp_ready,
  output logic [31:0]       rsp_rdata,
  output logic              rsp_err,
  output logic              mem_en,
  output logic [3:0]        mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [31:0]       mem_di,
  input  logic [31:0]       mem_dout
);

  state_t      state;
  logic [1:0]  ld_off;
  logic [2:0]  ld_f3;
  logic [31:0] ld_result;

  logic        f3_illegal;
  logic        misaligned;
  logic        out_of_range;
  logic        req_err;
  logic        accept;
  logic        mem_go;
  logic [3:0]  st_we;
  logic [31:0] st_di;

  always_comb begin
    f3_illegal   = !(req_funct3 inside {F3_B, F3_H, F3_W, F3_BU, F3_HU}) ||
                   (req_we && req_funct3[2]);
    misaligned   = ((req_funct3[1:0] == 2'b01) && req_addr[0]) ||
                   ((req_funct3[1:0] == 2'b10) && (req_addr[1:0] != 2'b00));
    out_of_range = (req_addr >> (ADDR_W + 2)) != 32'd0;
    req_err      = f3_illegal || misaligned || out_of_range;
  end

  // Halfword lanes are 0 or 2 once misalignment is excluded, so a plain shift suffices.
  always_comb begin
    st_we = 4'b1111;
    st_di = req_wdata;
    case (req_funct3)
      F3_B: begin
        st_we = 4'b0001 << req_addr[1:0];
        st_di = {4{req_wdata[7:0]}};
      end
      F3_H: begin
        st_we = 4'b0011 << req_addr[1:0];
        st_di = {2{req_wdata[15:0]}};
      end
      default: ;
    endcase
  end

  assign req_ready = rst_n && (state == IDLE);
  assign accept    = req_valid && req_ready;
  assign mem_go    = accept && !req_err;
  assign mem_en    = mem_go;
  assign mem_we    = (mem_go && req_we) ? st_we : 4'b0000;
  assign mem_addr  = mem_go ? req_addr[ADDR_W+1:2] : '0;
  assign mem_di    = (mem_go && req_we) ? st_di : 32'd0;

  load_formatter u_fmt (
    .mem_dout (mem_dout),
    .offset   (ld_off),
    .funct3   (ld_f3),
    .result   (ld_result)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      rsp_valid <= 1'b0;
      rsp_rdata <= 32'd0;
      rsp_err   <= 1'b0;
      ld_off    <= 2'd0;
      ld_f3     <= 3'd0;
    end else begin
      case (state)
        IDLE: begin
          if (accept) begin
            ld_off <= req_addr[1:0];
            ld_f3  <= req_funct3;
            if (req_err || req_we) begin
              state     <= RESP;
              rsp_valid <= 1'b1;
              rsp_rdata <= 32'd0;
              rsp_err   <= req_err;
            end else begin
              state <= LOAD_WAIT;
            end
          end
        end
        LOAD_WAIT: begin
          state     <= RESP;
          rsp_valid <= 1'b1;
          rsp_rdata <= ld_result;
          rsp_err   <= 1'b0;
        end
        RESP: begin
          if (rsp_ready) begin
            state     <= IDLE;
            rsp_valid <= 1'b0;
          end
        end
        default: begin
          state     <= IDLE;
          rsp_valid <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_load_store_unit.sv
// tb/tb_load_store_unit.sv - directed self-checking bench for load_store_unit
module tb_load_store_unit;
  import lsu_pkg::*;

  localparam int ADDR_W = 10;

  logic              clk = 1'b0;
  logic              rst_n;
  logic              req_valid;
  logic              req_ready;
  logic              req_we;
  logic [2:0]        req_funct3;
  logic [31:0]       req_addr;
  logic [31:0]       req_wdata;
  logic              rsp_valid;
  logic              rsp_ready;
  logic [31:0]       rsp_rdata;
  logic              rsp_err;
  logic              mem_en;
  logic [3:0]        mem_we;
  logic [ADDR_W-1:0] mem_addr;
  logic [31:0]       mem_di;
  logic [31:0]       mem_dout;

  int checks = 0;
  int errors = 0;
  int en_cnt = 0;

  logic [31:0] ram [0:(1<<ADDR_W)-1];

  load_store_unit #(.ADDR_W(ADDR_W)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .req_valid  (req_valid),
    .req_ready  (req_ready),
    .req_we     (req_we),
    .req_funct3 (req_funct3),
    .req_addr   (req_addr),
    .req_wdata  (req_wdata),
    .rsp_valid  (rsp_valid),
    .rsp_ready  (rsp_ready),
    .rsp_rdata  (rsp_rdata),
    .rsp_err    (rsp_err),
    .mem_en     (mem_en),
    .mem_we     (mem_we),
    .mem_addr   (mem_addr),
    .mem_di     (mem_di),
    .mem_dout   (mem_dout)
  );

  always #5 clk = ~clk;

  // Write-first byte-enabled RAM with one cycle of read latency.
  always @(posedge clk) begin
    if (mem_en === 1'b1) begin
      logic [31:0] w;
      en_cnt++;
      w = ram[mem_addr];
      for (int i = 0; i < 4; i++)
        if (mem_we[i]) w[8*i +: 8] = mem_di[8*i +: 8];
      ram[mem_addr] <= w;
      mem_dout      <= w;
    end
  end

  logic        o_en;
  logic [3:0]  o_we;
  logic [31:0] o_addr;
  logic [31:0] o_di;
  int          o_lat;
  logic [31:0] o_rdata;
  logic        o_err;
  int          o_en_delta;

  // Called just after a negedge with the unit idle; returns at the negedge where
  // rsp_valid is first seen, then (if rsp_ready) one negedge past the handshake.
  task automatic do_req(input logic we, input logic [2:0] f3, input logic [31:0] addr,
                        input logic [31:0] wdata);
    int en0;
    req_valid  = 1'b1;
    req_we     = we;
    req_funct3 = f3;
    req_addr   = addr;
    req_wdata  = wdata;
    #1;
    o_en   = mem_en;
    o_we   = mem_we;
    o_addr = 32'(mem_addr);
    o_di   = mem_di;
    en0    = en_cnt;
    @(posedge clk);
    @(negedge clk);
    req_valid = 1'b0;
    o_lat = 1;
    while (rsp_valid !== 1'b1 && o_lat < 8) begin
      @(negedge clk);
      o_lat++;
    end
    o_rdata    = rsp_rdata;
    o_err      = rsp_err;
    o_en_delta = en_cnt - en0;
    if (rsp_ready) @(negedge clk);
  endtask

  task automatic test_reset;
    rst_n      = 1'b0;
    req_valid  = 1'b1;
    req_we     = 1'b0;
    req_funct3 = F3_W;
    req_addr   = 32'h10;
    req_wdata  = 32'd0;
    rsp_ready  = 1'b1;
    repeat (2) @(negedge clk);
    checks++; if (req_ready !== 1'b0) begin errors++; $display("FAIL reset_req_ready: got %b expected 0", req_ready); end
    checks++; if (mem_en !== 1'b0) begin errors++; $display("FAIL reset_mem_en: got %b expected 0", mem_en); end
    checks++; if (mem_we !== 4'b0000) begin errors++; $display("FAIL reset_mem_we: got %b expected 0000", mem_we); end
    checks++; if (rsp_valid !== 1'b0) begin errors++; $display("FAIL reset_rsp_valid: got %b expected 0", rsp_valid); end
    req_valid = 1'b0;
    rst_n     = 1'b1;
    @(negedge clk);
    checks++; if (req_ready !== 1'b1) begin errors++; $display("FAIL reset_release_ready: got %b expected 1", req_ready); end
    checks++; if (dut.state !== IDLE) begin errors++; $display("FAIL reset_state: got %0d expected IDLE", dut.state); end
  endtask

  task automatic test_store_word;
    do_req(1'b1, F3_W, 32'h10, 32'hDEADBEEF);
    checks++; if (o_en !== 1'b1) begin errors++; $display("FAIL sw_mem_en: got %b expected 1", o_en); end
    checks++; if (o_we !== 4'b1111) begin errors++; $display("FAIL sw_mem_we: got %b expected 1111", o_we); end
    checks++; if (o_addr !== 32'd4) begin errors++; $display("FAIL sw_mem_addr: got %0d expected 4", o_addr); end
    checks++; if (o_di !== 32'hDEADBEEF) begin errors++; $display("FAIL sw_mem_di: got %h expected deadbeef", o_di); end
    checks++; if (o_lat !== 1) begin errors++; $display("FAIL sw_latency: got %0d expected 1", o_lat); end
    checks++; if (o_err !== 1'b0 || o_rdata !== 32'd0) begin errors++; $display("FAIL sw_rsp: got err=%b rdata=%h expected err=0 rdata=0", o_err, o_rdata); end
  endtask

  task automatic test_store_byte;
    do_req(1'b1, F3_B, 32'h13, 32'h000000A5);
    checks++; if (o_we !== 4'b1000) begin errors++; $display("FAIL sb_mem_we: got %b expected 1000", o_we); end
    checks++; if (o_di !== 32'hA5A5A5A5) begin errors++; $display("FAIL sb_mem_di: got %h expected a5a5a5a5", o_di); end
    checks++; if (o_lat !== 1 || o_err !== 1'b0) begin errors++; $display("FAIL sb_rsp: got lat=%0d err=%b expected lat=1 err=0", o_lat, o_err); end
    do_req(1'b0, F3_W, 32'h10, 32'd0);
    checks++; if (o_we !== 4'b0000 || o_en !== 1'b1) begin errors++; $display("FAIL lw_mem_ctrl: got en=%b we=%b expected en=1 we=0000", o_en, o_we); end
    checks++; if (o_lat !== 2) begin errors++; $display("FAIL lw_latency: got %0d expected 2", o_lat); end
    checks++; if (o_rdata !== 32'hA5ADBEEF) begin errors++; $display("FAIL lw_after_sb: got %h expected a5adbeef", o_rdata); end
  endtask

  task automatic test_load_extend;
    logic [2:0]  f3  [5] = '{F3_B, F3_BU, F3_H, F3_HU, F3_W};
    logic [31:0] ad  [5] = '{32'h11, 32'h11, 32'h12, 32'h12, 32'h10};
    logic [31:0] exp [5] = '{32'hFFFFFFAA, 32'h000000AA, 32'hFFFF8899, 32'h00008899, 32'h8899AABB};
    do_req(1'b1, F3_W, 32'h10, 32'h8899AABB);
    for (int i = 0; i < 5; i++) begin
      do_req(1'b0, f3[i], ad[i], 32'd0);
      checks++;
      if (o_rdata !== exp[i] || o_err !== 1'b0 || o_lat !== 2) begin
        errors++;
        $display("FAIL load_ext[%0d]: got rdata=%h err=%b lat=%0d expected rdata=%h err=0 lat=2", i, o_rdata, o_err, o_lat, exp[i]);
      end
    end
    do_req(1'b1, F3_H, 32'h12, 32'h00001234);
    checks++; if (o_we !== 4'b1100 || o_di !== 32'h12341234) begin errors++; $display("FAIL sh_lanes: got we=%b di=%h expected we=1100 di=12341234", o_we, o_di); end
    do_req(1'b0, F3_W, 32'h10, 32'd0);
    checks++; if (o_rdata !== 32'h1234AABB) begin errors++; $display("FAIL lw_after_sh: got %h expected 1234aabb", o_rdata); end
  endtask

  task automatic test_errors;
    logic        we [5] = '{1'b0, 1'b1, 1'b0, 1'b0, 1'b1};
    logic [2:0]  f3 [5] = '{F3_W, F3_H, F3_W, 3'b011, F3_BU};
    logic [31:0] ad [5] = '{32'h12, 32'h11, 32'h1000, 32'h10, 32'h10};
    for (int i = 0; i < 5; i++) begin
      do_req(we[i], f3[i], ad[i], 32'hFFFFFFFF);
      checks++;
      if (o_en !== 1'b0 || o_en_delta !== 0 || o_lat !== 1 || o_err !== 1'b1 || o_rdata !== 32'd0) begin
        errors++;
        $display("FAIL error[%0d]: got en=%b en_cycles=%0d lat=%0d err=%b rdata=%h expected en=0 en_cycles=0 lat=1 err=1 rdata=0",
                 i, o_en, o_en_delta, o_lat, o_err, o_rdata);
      end
    end
  endtask

  task automatic test_backpressure;
    rsp_ready = 1'b0;
    do_req(1'b0, F3_W, 32'h10, 32'd0);
    checks++; if (o_lat !== 2 || o_rdata !== 32'h1234AABB) begin errors++; $display("FAIL bp_first: got lat=%0d rdata=%h expected lat=2 rdata=1234aabb", o_lat, o_rdata); end
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      checks++;
      if (rsp_valid !== 1'b1 || rsp_rdata !== 32'h1234AABB || rsp_err !== 1'b0 || req_ready !== 1'b0) begin
        errors++;
        $display("FAIL bp_hold[%0d]: got valid=%b rdata=%h err=%b ready=%b expected valid=1 rdata=1234aabb err=0 ready=0",
                 i, rsp_valid, rsp_rdata, rsp_err, req_ready);
      end
    end
    rsp_ready = 1'b1;
    @(negedge clk);
    checks++; if (rsp_valid !== 1'b0 || req_ready !== 1'b1) begin errors++; $display("FAIL bp_release: got valid=%b ready=%b expected valid=0 ready=1", rsp_valid, req_ready); end
    do_req(1'b0, F3_BU, 32'h13, 32'd0);
    checks++; if (o_en !== 1'b1 || o_rdata !== 32'h00000012) begin errors++; $display("FAIL bp_next: got en=%b rdata=%h expected en=1 rdata=00000012", o_en, o_rdata); end
  endtask

  task automatic test_reset_midop;
    req_valid  = 1'b1;
    req_we     = 1'b0;
    req_funct3 = F3_W;
    req_addr   = 32'h10;
    @(posedge clk);
    @(negedge clk);
    req_valid = 1'b0;
    rst_n     = 1'b0;
    #1;
    checks++; if (rsp_valid !== 1'b0 || req_ready !== 1'b0) begin errors++; $display("FAIL midop_reset: got valid=%b ready=%b expected valid=0 ready=0", rsp_valid, req_ready); end
    @(negedge clk);
    rst_n = 1'b1;
    repeat (2) @(negedge clk);
    checks++; if (rsp_valid !== 1'b0 || req_ready !== 1'b1) begin errors++; $display("FAIL midop_after: got valid=%b ready=%b expected valid=0 ready=1", rsp_valid, req_ready); end
  endtask

  initial begin
    test_reset();
    test_store_word();
    test_store_byte();
    test_load_extend();
    test_errors();
    test_backpressure();
    test_reset_midop();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
